// File: rtl/cubic_edge_checker.sv
// Degree checker for a netlist edge stream: clears a per-node degree table, accumulates
// edges, then scans for the first node whose degree differs from TARGET_DEG.
// Optional macro CUBIC_EDGE_COUNT_CHECK_EN adds err_count (total edge count check).
module cubic_edge_checker #(
  parameter int N_NODES    = 70,
  parameter int NODE_W     = 7,
  parameter int TARGET_DEG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              edge_valid,
  output logic              edge_ready,
  input  logic [NODE_W-1:0] edge_u,
  input  logic [NODE_W-1:0] edge_v,
  input  logic              edge_last,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              err_self,
  output logic              err_range,
  output logic [NODE_W-1:0] bad_node,
  output logic [2:0]        bad_deg,
  output logic [15:0]       edge_count
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
  ,
  output logic              err_count
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SCAN, DONE} state_t;

  localparam logic [NODE_W-1:0] LAST_IDX  = NODE_W'(N_NODES - 1);
  localparam logic [15:0]       EXP_EDGES = 16'(N_NODES * TARGET_DEG / 2);
  localparam logic [2:0]        TGT       = 3'(TARGET_DEG);

  state_t                     state_q, state_d;
  logic [NODE_W-1:0]          idx_q;
  logic [N_NODES-1:0][2:0]    deg_q, deg_d;
  logic                       found_q;
  logic                       xfer, u_ok, v_ok, cnt_bad;

  function automatic logic [2:0] sat_add(input logic [2:0] d, input logic [1:0] n);
    logic [3:0] s;
    s = {1'b0, d} + {2'b0, n};
    return (s > 4'd7) ? 3'd7 : s[2:0];
  endfunction

  assign u_ok = int'(edge_u) < N_NODES;
  assign v_ok = int'(edge_v) < N_NODES;
  assign xfer = edge_valid && edge_ready;
  assign busy = (state_q != IDLE);

`ifdef CUBIC_EDGE_COUNT_CHECK_EN
  assign cnt_bad = (edge_count != EXP_EDGES);
`else
  assign cnt_bad = 1'b0;
`endif

  // A self-loop hits the same entry through both endpoint terms, giving +2.
  always_comb begin
    deg_d = deg_q;
    for (int i = 0; i < N_NODES; i++) begin
      if (state_q == CLEAR && idx_q == NODE_W'(i))
        deg_d[i] = '0;
      else if (xfer)
        deg_d[i] = sat_add(deg_q[i], {1'b0, u_ok && edge_u == NODE_W'(i)}
                                   + {1'b0, v_ok && edge_v == NODE_W'(i)});
    end
  end

  always_ff @(posedge clk) deg_q <= deg_d;

  always_comb begin
    state_d    = state_q;
    edge_ready = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: if (idx_q == LAST_IDX) state_d = LOAD;
      LOAD: begin
        edge_ready = 1'b1;
        if (edge_valid && edge_last) state_d = SCAN;
      end
      SCAN:  if (idx_q == LAST_IDX) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      found_q    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_self   <= 1'b0;
      err_range  <= 1'b0;
      bad_node   <= '0;
      bad_deg    <= '0;
      edge_count <= '0;
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
      err_count  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          idx_q      <= '0;
          found_q    <= 1'b0;
          pass       <= 1'b0;
          err_self   <= 1'b0;
          err_range  <= 1'b0;
          bad_node   <= '0;
          bad_deg    <= '0;
          edge_count <= '0;
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
          err_count  <= 1'b0;
`endif
        end
        CLEAR: idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + NODE_W'(1);
        LOAD: if (xfer) begin
          if (edge_count != 16'hFFFF) edge_count <= edge_count + 16'd1;
          if (u_ok && edge_u == edge_v) err_self <= 1'b1;
          if (!u_ok || !v_ok) err_range <= 1'b1;
        end
        SCAN: begin
          idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + NODE_W'(1);
          if (!found_q && deg_q[idx_q] != TGT) begin
            found_q  <= 1'b1;
            bad_node <= idx_q;
            bad_deg  <= deg_q[idx_q];
          end
        end
        DONE: begin
          done <= 1'b1;
          pass <= !found_q && !err_self && !err_range && !cnt_bad;
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
          err_count <= cnt_bad;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cubic_edge_checker.sv
// Bench for cubic_edge_checker: a 4-node and a 3-node instance, directed cases plus
// randomized edge lists checked against a degree-table reference model.
module tb_cubic_edge_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b, edge_valid, edge_last;
  logic [1:0] edge_u, edge_v;
  logic       a_ready, a_busy, a_done, a_pass, a_err_self, a_err_range;
  logic       b_ready, b_busy, b_done, b_pass, b_err_self, b_err_range;
  logic [1:0] a_bad_node, b_bad_node;
  logic [2:0] a_bad_deg, b_bad_deg;
  logic [15:0] a_edge_count, b_edge_count;
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
  logic a_err_count, b_err_count;
`else
  wire  a_err_count = 1'b0;
  wire  b_err_count = 1'b0;
`endif

  cubic_edge_checker #(.N_NODES(4), .NODE_W(2), .TARGET_DEG(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .edge_valid(edge_valid), .edge_ready(a_ready),
    .edge_u(edge_u), .edge_v(edge_v), .edge_last(edge_last), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_self(a_err_self), .err_range(a_err_range), .bad_node(a_bad_node),
    .bad_deg(a_bad_deg), .edge_count(a_edge_count)
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
    , .err_count(a_err_count)
`endif
  );

  cubic_edge_checker #(.N_NODES(3), .NODE_W(2), .TARGET_DEG(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .edge_valid(edge_valid), .edge_ready(b_ready),
    .edge_u(edge_u), .edge_v(edge_v), .edge_last(edge_last), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_self(b_err_self), .err_range(b_err_range), .bad_node(b_bad_node),
    .bad_deg(b_bad_deg), .edge_count(b_edge_count)
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
    , .err_count(b_err_count)
`endif
  );

  typedef struct packed {
    logic        pass, es, er, ec;
    logic [1:0]  bn;
    logic [2:0]  bd;
    logic [15:0] cnt;
  } res_t;

  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0;
  bit tmo;
  int eu[$], ev[$];
  int k4u[6] = '{0, 0, 0, 1, 1, 2};
  int k4v[6] = '{1, 2, 3, 2, 3, 3};

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: degree table with saturation, then first-mismatch search.
  function automatic res_t model(input int n);
    int   deg[4];
    res_t r;
    bit   found = 0;
    r = '0;
    for (int i = 0; i < 4; i++) deg[i] = 0;
    foreach (eu[k]) begin
      if (eu[k] < n) deg[eu[k]] = (deg[eu[k]] + 1 > 7) ? 7 : deg[eu[k]] + 1;
      if (ev[k] < n) deg[ev[k]] = (deg[ev[k]] + 1 > 7) ? 7 : deg[ev[k]] + 1;
      if (eu[k] == ev[k] && eu[k] < n) r.es = 1;
      if (eu[k] >= n || ev[k] >= n) r.er = 1;
    end
    r.cnt = 16'(eu.size());
    for (int i = 0; i < n; i++)
      if (!found && deg[i] != 3) begin
        found = 1; r.bn = 2'(i); r.bd = 3'(deg[i]);
      end
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
    r.ec = (eu.size() != n * 3 / 2);
`endif
    r.pass = !found && !r.es && !r.er && !r.ec;
    return r;
  endfunction

  task automatic set_k4();
    eu.delete(); ev.delete();
    for (int i = 0; i < 6; i++) begin eu.push_back(k4u[i]); ev.push_back(k4v[i]); end
  endtask

  task automatic send_edge(input int which, input int u, input int v, input bit last);
    int n = 0;
    edge_valid = 1'b1; edge_u = 2'(u); edge_v = 2'(v); edge_last = last;
    while (!((which != 0) ? b_ready : a_ready) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) tmo = 1;
    @(negedge clk);
    edge_valid = 1'b0; edge_last = 1'b0;
  endtask

  task automatic run_list(input int which, input bit gaps, input int hold,
                          output res_t obs, output int lat);
    int n = 0;
    tmo = 0;
    @(negedge clk);
    if (which != 0) start_b = 1'b1; else start_a = 1'b1;
    start_cyc = cyc + 1;
    repeat (hold) @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    foreach (eu[k]) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_edge(which, eu[k], ev[k], k == eu.size() - 1);
    end
    while (!((which != 0) ? b_done : a_done) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) tmo = 1;
    lat = cyc - start_cyc;
    if (which != 0) obs = '{b_pass, b_err_self, b_err_range, b_err_count, b_bad_node, b_bad_deg, b_edge_count};
    else            obs = '{a_pass, a_err_self, a_err_range, a_err_count, a_bad_node, a_bad_deg, a_edge_count};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({a_ready, a_busy, a_done, a_pass, a_err_self, a_err_range, a_err_count, a_bad_node, a_bad_deg, a_edge_count} !== '0) begin
      miscompares++; $display("FAIL reset_a: got busy=%b done=%b pass=%b cnt=%0d want all zero", a_busy, a_done, a_pass, a_edge_count);
    end
    vectors++;
    if ({b_ready, b_busy, b_done, b_pass, b_err_self, b_err_range, b_err_count, b_bad_node, b_bad_deg, b_edge_count} !== '0) begin
      miscompares++; $display("FAIL reset_b: got busy=%b done=%b pass=%b cnt=%0d want all zero", b_busy, b_done, b_pass, b_edge_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_k4();
    res_t obs, exp; int lat;
    set_k4(); exp = model(4);
    run_list(0, 0, 1, obs, lat);
    vectors++; if (tmo) begin miscompares++; $display("FAIL k4_timeout: got timeout want done"); end
    vectors++; if (obs !== exp) begin miscompares++; $display("FAIL k4_result: got %h want %h", obs, exp); end
    vectors++; if (lat !== 15) begin miscompares++; $display("FAIL k4_latency: got %0d want 15", lat); end
    vectors++; if (obs.pass !== 1'b1 || obs.cnt !== 16'd6) begin
      miscompares++; $display("FAIL k4_pass: got pass=%b cnt=%0d want pass=1 cnt=6", obs.pass, obs.cnt); end
    @(negedge clk);
    vectors++; if (a_done !== 1'b0 || a_pass !== 1'b1) begin
      miscompares++; $display("FAIL k4_hold: got done=%b pass=%b want done=0 pass=1", a_done, a_pass); end
  endtask

  task automatic test_missing_edge();
    res_t obs, exp; int lat;
    set_k4(); void'(eu.pop_back()); void'(ev.pop_back()); exp = model(4);
    run_list(0, 0, 1, obs, lat);
    vectors++; if (obs !== exp || tmo) begin miscompares++; $display("FAIL missing_result: got %h want %h", obs, exp); end
    vectors++; if (obs.pass !== 1'b0 || obs.bn !== 2'd2 || obs.bd !== 3'd2 || obs.cnt !== 16'd5) begin
      miscompares++; $display("FAIL missing_fields: got pass=%b node=%0d deg=%0d cnt=%0d want 0/2/2/5", obs.pass, obs.bn, obs.bd, obs.cnt); end
  endtask

  task automatic test_self_loop();
    res_t obs, exp; int lat;
    set_k4(); eu.push_back(1); ev.push_back(1); exp = model(4);
    run_list(0, 1, 1, obs, lat);
    vectors++; if (obs !== exp || tmo) begin miscompares++; $display("FAIL self_result: got %h want %h", obs, exp); end
    vectors++; if (obs.es !== 1'b1 || obs.pass !== 1'b0 || obs.bn !== 2'd1 || obs.bd !== 3'd5) begin
      miscompares++; $display("FAIL self_fields: got es=%b pass=%b node=%0d deg=%0d want 1/0/1/5", obs.es, obs.pass, obs.bn, obs.bd); end
  endtask

  task automatic test_range();
    res_t obs, exp; int lat;
    eu = '{0}; ev = '{3}; exp = model(3);
    run_list(1, 0, 1, obs, lat);
    vectors++; if (obs !== exp || tmo) begin miscompares++; $display("FAIL range_result: got %h want %h", obs, exp); end
    vectors++; if (obs.er !== 1'b1 || obs.pass !== 1'b0 || obs.bn !== 2'd0 || obs.bd !== 3'd1) begin
      miscompares++; $display("FAIL range_fields: got er=%b pass=%b node=%0d deg=%0d want 1/0/0/1", obs.er, obs.pass, obs.bn, obs.bd); end
  endtask

  task automatic test_saturation();
    res_t obs, exp; int lat;
    eu.delete(); ev.delete();
    repeat (10) begin eu.push_back(0); ev.push_back(1); end
    exp = model(4);
    run_list(0, 0, 1, obs, lat);
    vectors++; if (obs !== exp || tmo) begin miscompares++; $display("FAIL sat_result: got %h want %h", obs, exp); end
    vectors++; if (obs.bn !== 2'd0 || obs.bd !== 3'd7 || obs.cnt !== 16'd10) begin
      miscompares++; $display("FAIL sat_fields: got node=%0d deg=%0d cnt=%0d want 0/7/10", obs.bn, obs.bd, obs.cnt); end
  endtask

  task automatic test_reset_mid_load();
    res_t obs; int lat;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    vectors++; if (a_busy !== 1'b1) begin miscompares++; $display("FAIL midload_busy: got %b want 1", a_busy); end
    tmo = 0;
    send_edge(0, 0, 1, 0); send_edge(0, 0, 2, 0); send_edge(0, 0, 3, 0);
    edge_valid = 1'b1; edge_u = 2'd1; edge_v = 2'd2; rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tmo || {a_ready, a_busy, a_done, a_pass, a_err_self, a_err_range, a_err_count, a_bad_node, a_bad_deg, a_edge_count} !== '0) begin
      miscompares++; $display("FAIL midload_reset: got busy=%b ready=%b cnt=%0d want all zero", a_busy, a_ready, a_edge_count); end
    edge_valid = 1'b0; rst = 1'b0;
    set_k4();
    run_list(0, 0, 1, obs, lat);
    vectors++; if (tmo || obs.pass !== 1'b1 || obs.cnt !== 16'd6) begin
      miscompares++; $display("FAIL midload_restart: got pass=%b cnt=%0d want pass=1 cnt=6", obs.pass, obs.cnt); end
  endtask

  task automatic test_duplicate_edge();
    res_t obs, exp; int lat;
    set_k4(); eu.push_back(0); ev.push_back(1); exp = model(4);
    run_list(0, 0, 2, obs, lat);
    vectors++; if (obs !== exp || tmo) begin miscompares++; $display("FAIL dup_result: got %h want %h", obs, exp); end
`ifdef CUBIC_EDGE_COUNT_CHECK_EN
    vectors++; if (obs.ec !== 1'b1) begin miscompares++; $display("FAIL dup_err_count: got %b want 1", obs.ec); end
    set_k4();
    run_list(0, 0, 1, obs, lat);
    vectors++; if (obs.ec !== 1'b0) begin miscompares++; $display("FAIL k4_err_count: got %b want 0", obs.ec); end
`endif
  endtask

  task automatic test_random();
    res_t obs, exp; int lat, which, m, p[6], t, j;
    for (int it = 0; it < 30; it++) begin
      which = $urandom_range(0, 1);
      eu.delete(); ev.delete();
      if (which == 0 && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 6; i++) p[i] = i;
        for (int i = 5; i > 0; i--) begin j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t; end
        for (int i = 0; i < 6; i++)
          if ($urandom_range(0, 1) != 0) begin eu.push_back(k4u[p[i]]); ev.push_back(k4v[p[i]]); end
          else begin eu.push_back(k4v[p[i]]); ev.push_back(k4u[p[i]]); end
      end else begin
        m = $urandom_range(1, 12);
        repeat (m) begin eu.push_back($urandom_range(0, 3)); ev.push_back($urandom_range(0, 3)); end
      end
      exp = model(which != 0 ? 3 : 4);
      run_list(which, 1, $urandom_range(1, 3), obs, lat);
      vectors++; if (tmo) begin miscompares++; $display("FAIL rand_timeout it=%0d: got timeout want done", it); end
      vectors++; if (obs !== exp) begin miscompares++; $display("FAIL rand_result it=%0d dut=%0d: got %h want %h", it, which, obs, exp); end
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    edge_valid = 1'b0; edge_last = 1'b0; edge_u = '0; edge_v = '0;
    test_reset();
    test_k4();
    test_missing_edge();
    test_self_loop();
    test_range();
    test_saturation();
    test_reset_mid_load();
    test_duplicate_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
